// File: rtl/motion_scheduler.sv
// motion_scheduler
// Sequences cursor motion for the VGA demo. Owns the splash timer, the
// input-mode register and the cursor position. It grants one motion source
// per step period. The sources are the buttons, the accelerometer and the
// joystick. In mode 00 those sources share the cursor round-robin.
//
// Ports
//   vga_clk            sole clock
//   rst                synchronous active-high reset
//   js_button_a..d     active-low up/right/down/left buttons
//   js_button_f_d      mode-change level, rising edge steps the mode
//   joystick_data_x/y  12-bit joystick samples
//   accel_data_x/y     16-bit accelerometer samples
//   pos_c / pos_r      cursor column / row
//   splash_active      high during the splash phase
//   mode               11 buttons, 10 accel, 01 joystick, 00 arbitrated
//   grant              one-hot grant of the current move (0 btn, 1 acc, 2 js)
//   step_pulse         one-cycle strobe when the position updates
module motion_scheduler #(
  parameter int          SPLASH_CYCLES = 100_000_000,
  parameter int          STEP_PERIOD   = 250_000,
  parameter int          MAX_C         = 639,
  parameter int          MAX_R         = 479,
  parameter int          INIT_C        = 320,
  parameter int          INIT_R        = 240,
  parameter logic [7:0]  JS_HI         = 8'hF0,
  parameter logic [7:0]  JS_LO         = 8'h1F
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic        js_button_a,
  input  logic        js_button_b,
  input  logic        js_button_c,
  input  logic        js_button_d,
  input  logic        js_button_f_d,
  input  logic [11:0] joystick_data_x,
  input  logic [11:0] joystick_data_y,
  input  logic [15:0] accel_data_x,
  input  logic [15:0] accel_data_y,
  output logic [9:0]  pos_c,
  output logic [8:0]  pos_r,
  output logic        splash_active,
  output logic [1:0]  mode,
  output logic [2:0]  grant,
  output logic        step_pulse
);

  localparam int SPL_W = (SPLASH_CYCLES > 1) ? $clog2(SPLASH_CYCLES) : 1;
  localparam int STP_W = (STEP_PERIOD > 1) ? $clog2(STEP_PERIOD) : 1;
  localparam logic [SPL_W-1:0] SPL_LAST = SPL_W'(SPLASH_CYCLES - 1);
  localparam logic [STP_W-1:0] STP_LAST = STP_W'(STEP_PERIOD - 1);

  typedef enum logic [1:0] {
    S_SPLASH = 2'd0,
    S_WAIT   = 2'd1,
    S_ARB    = 2'd2,
    S_MOVE   = 2'd3
  } state_t;

  // Round-robin successor over the three source indices.
  function automatic logic [1:0] f_next3(input logic [1:0] idx);
    case (idx)
      2'd0:    return 2'd1;
      2'd1:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // Registered input copies
  logic        r_btn_a, r_btn_b, r_btn_c, r_btn_d;
  logic        r_f, r_f_d;
  logic [11:0] r_jx, r_jy;
  logic [15:0] r_ax, r_ay;

  // FSM and datapath registers
  state_t           r_state;
  logic [SPL_W-1:0] r_splash_cnt;
  logic [STP_W-1:0] r_step_cnt;
  logic [1:0]       r_mode;
  logic [1:0]       r_rr_ptr;
  logic [1:0]       r_sel_idx;
  logic             r_sel_rr;
  logic [1:0]       r_dx, r_dy;
  logic [9:0]       r_pos_c;
  logic [8:0]       r_pos_r;
  logic             r_splash;
  logic [2:0]       r_grant;
  logic             r_step_pulse;

  // Direction encoding: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0
  logic [1:0] w_dx_btn, w_dy_btn, w_dx_acc, w_dy_acc, w_dx_js, w_dy_js;
  logic [3:0] w_req;
  logic [1:0] w_c0, w_c1, w_c2;
  logic       w_sel_valid;
  logic [1:0] w_sel_idx;
  logic [1:0] w_sel_dx, w_sel_dy;
  logic       w_f_rise;
  logic       w_unused;

  assign w_f_rise = r_f & ~r_f_d;
  assign w_c0     = f_next3(r_rr_ptr);
  assign w_c1     = f_next3(w_c0);
  assign w_c2     = f_next3(w_c1);
  // Low sample bits take no part in the direction decode.
  assign w_unused = ^{r_jx[3:0], r_jy[3:0], r_ax[7:0], r_ay[7:0]};

  // Register every input once before decode.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_btn_a <= 1'b1;
      r_btn_b <= 1'b1;
      r_btn_c <= 1'b1;
      r_btn_d <= 1'b1;
      r_f     <= 1'b0;
      r_f_d   <= 1'b0;
      r_jx    <= 12'h800;
      r_jy    <= 12'h800;
      r_ax    <= 16'h8000;
      r_ay    <= 16'h8000;
    end else begin
      r_btn_a <= js_button_a;
      r_btn_b <= js_button_b;
      r_btn_c <= js_button_c;
      r_btn_d <= js_button_d;
      r_f     <= js_button_f_d;
      r_f_d   <= r_f;
      r_jx    <= joystick_data_x;
      r_jy    <= joystick_data_y;
      r_ax    <= accel_data_x;
      r_ay    <= accel_data_y;
    end
  end

  // Per-source direction decode from the registered inputs.
  always_comb begin
    w_dx_btn = 2'b00;
    w_dy_btn = 2'b00;
    w_dx_acc = 2'b00;
    w_dy_acc = 2'b00;
    w_dx_js  = 2'b00;
    w_dy_js  = 2'b00;
    // Left beats right, down beats up.
    if (!r_btn_d)      w_dx_btn = 2'b11;
    else if (!r_btn_b) w_dx_btn = 2'b01;
    else               w_dx_btn = 2'b00;
    if (!r_btn_c)      w_dy_btn = 2'b01;
    else if (!r_btn_a) w_dy_btn = 2'b11;
    else               w_dy_btn = 2'b00;
    if (r_ax[15:8] == 8'h00)      w_dx_acc = 2'b11;
    else if (r_ax[15:8] == 8'hFF) w_dx_acc = 2'b01;
    else                          w_dx_acc = 2'b00;
    if (r_ay[15:8] == 8'h00)      w_dy_acc = 2'b01;
    else if (r_ay[15:8] == 8'hFF) w_dy_acc = 2'b11;
    else                          w_dy_acc = 2'b00;
    if (r_jx[11:4] > JS_HI)       w_dx_js = 2'b01;
    else if (r_jx[11:4] < JS_LO)  w_dx_js = 2'b11;
    else                          w_dx_js = 2'b00;
    if (r_jy[11:4] > JS_HI)       w_dy_js = 2'b11;
    else if (r_jy[11:4] < JS_LO)  w_dy_js = 2'b01;
    else                          w_dy_js = 2'b00;
    w_req = {1'b0, |{w_dx_js, w_dy_js}, |{w_dx_acc, w_dy_acc}, |{w_dx_btn, w_dy_btn}};
  end

  // Source selection for the ARB slot; mode 00 searches from rr_ptr+1.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = 2'd0;
    case (r_mode)
      2'b11: begin w_sel_idx = 2'd0; w_sel_valid = w_req[0]; end
      2'b10: begin w_sel_idx = 2'd1; w_sel_valid = w_req[1]; end
      2'b01: begin w_sel_idx = 2'd2; w_sel_valid = w_req[2]; end
      2'b00: begin
        if (w_req[w_c0])      begin w_sel_idx = w_c0; w_sel_valid = 1'b1; end
        else if (w_req[w_c1]) begin w_sel_idx = w_c1; w_sel_valid = 1'b1; end
        else if (w_req[w_c2]) begin w_sel_idx = w_c2; w_sel_valid = 1'b1; end
        else                  begin w_sel_idx = 2'd0; w_sel_valid = 1'b0; end
      end
      default: begin w_sel_idx = 2'd0; w_sel_valid = 1'b0; end
    endcase
    case (w_sel_idx)
      2'd0:    begin w_sel_dx = w_dx_btn; w_sel_dy = w_dy_btn; end
      2'd1:    begin w_sel_dx = w_dx_acc; w_sel_dy = w_dy_acc; end
      2'd2:    begin w_sel_dx = w_dx_js;  w_sel_dy = w_dy_js;  end
      default: begin w_sel_dx = 2'b00;    w_sel_dy = 2'b00;    end
    endcase
  end

  // Mode register, stepped down once per rising edge of the mode request.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_mode <= 2'b11;
    end else if (w_f_rise) begin
      r_mode <= r_mode - 2'd1;
    end else begin
      r_mode <= r_mode;
    end
  end

  // Splash / wait / arbitrate / move sequencer with registered outputs.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      r_state      <= S_SPLASH;
      r_splash_cnt <= '0;
      r_step_cnt   <= '0;
      r_rr_ptr     <= 2'd2;
      r_sel_idx    <= 2'd0;
      r_sel_rr     <= 1'b0;
      r_dx         <= 2'b00;
      r_dy         <= 2'b00;
      r_pos_c      <= 10'(INIT_C);
      r_pos_r      <= 9'(INIT_R);
      r_splash     <= 1'b1;
      r_grant      <= 3'b000;
      r_step_pulse <= 1'b0;
    end else begin
      r_step_pulse <= 1'b0;
      case (r_state)
        S_SPLASH: begin
          if (r_splash_cnt == SPL_LAST) begin
            r_splash_cnt <= '0;
            r_splash     <= 1'b0;
            r_state      <= S_WAIT;
          end else begin
            r_splash_cnt <= r_splash_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (r_step_cnt == STP_LAST) begin
            r_step_cnt <= '0;
            r_state    <= S_ARB;
          end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
          end
        end
        S_ARB: begin
          if (w_sel_valid) begin
            r_grant   <= 3'(3'b001 << w_sel_idx);
            r_sel_idx <= w_sel_idx;
            r_sel_rr  <= (r_mode == 2'b00);
            r_dx      <= w_sel_dx;
            r_dy      <= w_sel_dy;
            r_state   <= S_MOVE;
          end else begin
            r_grant   <= 3'b000;
            r_state   <= S_WAIT;
          end
        end
        S_MOVE: begin
          // Saturating update, each axis independent.
          if (r_dx == 2'b11 && r_pos_c != 10'd0)
            r_pos_c <= r_pos_c - 10'd1;
          else if (r_dx == 2'b01 && r_pos_c != 10'(MAX_C))
            r_pos_c <= r_pos_c + 10'd1;
          else
            r_pos_c <= r_pos_c;
          if (r_dy == 2'b11 && r_pos_r != 9'd0)
            r_pos_r <= r_pos_r - 9'd1;
          else if (r_dy == 2'b01 && r_pos_r != 9'(MAX_R))
            r_pos_r <= r_pos_r + 9'd1;
          else
            r_pos_r <= r_pos_r;
          if (r_sel_rr) r_rr_ptr <= r_sel_idx;
          else          r_rr_ptr <= r_rr_ptr;
          r_step_pulse <= 1'b1;
          r_state      <= S_WAIT;
        end
        default: begin
          r_state <= S_SPLASH;
        end
      endcase
    end
  end

  assign pos_c         = r_pos_c;
  assign pos_r         = r_pos_r;
  assign splash_active = r_splash;
  assign mode          = r_mode;
  assign grant         = r_grant;
  assign step_pulse    = r_step_pulse;

endmodule

// File: doc/motion_scheduler.md
# motion_scheduler

Sequences and arbitrates cursor motion for the VGA demo: owns the splash-screen timer, the input-mode register and the cursor position, and grants one motion source per step period. It sits between the raw input sources (four buttons, accelerometer, joystick) and the pixel-compare/colour stage, which consumes `pos_c`/`pos_r` and `splash_active`. In arbitrated mode (`mode == 2'b00`), concurrent requesters share the cursor through round-robin.

## Interface
- `SPLASH_CYCLES`, default 100_000_000: length of the splash phase, in clock cycles.
- `STEP_PERIOD`, default 250_000: number of WAIT cycles between arbitration slots.
- `MAX_C`, default 639: maximum column.
- `MAX_R`, default 479: maximum row.
- `INIT_C`, default 320: column after reset.
- `INIT_R`, default 240: row after reset.
- `JS_HI`, default 8'hF0: joystick high threshold.
- `JS_LO`, default 8'h1F: joystick low threshold.

Ports (one clock; reset is synchronous and active-high):
- `vga_clk  in  1`: sole clock, 25 MHz.
- `rst  in  1`: synchronous, active-high reset.
- `js_button_a`, `js_button_b`, `js_button_c`, `js_button_d  in  1 each`: active-low buttons for up, right, down and left.
- `js_button_f_d  in  1`: mode-change request, a level input; edge-detected internally.
- `joystick_data_x`, `joystick_data_y  in  12 each`: joystick samples.
- `accel_data_x`, `accel_data_y  in  16 each`: accelerometer samples.
- `pos_c  out  10`: cursor column.
- `pos_r  out  9`: cursor row.
- `splash_active  out  1`: high during the splash phase.
- `mode  out  2`: current mode. 11 = buttons, 10 = accel, 01 = joystick, 00 = arbitrated.
- `grant  out  3`: one-hot grant for the current move. Bit 0 = buttons, bit 1 = accel, bit 2 = joystick.
- `step_pulse  out  1`: one-cycle strobe when the position updates.

## Operation

**Input sampling**
- All inputs are registered once per cycle, including `js_button_f_d`.
- Decode works on the registered copies. dx and dy each take a value in {-1, 0, +1}.

**Direction decode per source**
- Buttons, horizontal: d low gives -1; else b low gives +1. If both d and b are low, d wins.
- Buttons, vertical: c low gives +1 (down); else a low gives -1. If both c and a are low, c wins.
- Accelerometer, horizontal: x[15:8] == 8'h00 gives -1; x[15:8] == 8'hFF gives +1.
- Accelerometer, vertical: y[15:8] == 8'h00 gives +1; y[15:8] == 8'hFF gives -1.
- Joystick, horizontal: x[11:4] > JS_HI gives +1; x[11:4] < JS_LO gives -1.
- Joystick, vertical: y[11:4] > JS_HI gives -1; y[11:4] < JS_LO gives +1.
- A source requests a move when its dx or dy is non-zero.

**Mode register**
- Resets to 11.
- Each rising edge of the registered `js_button_f_d` steps the mode down by one, with wrap-around: 11 → 10 → 01 → 00 → 11.
- A held level produces exactly one step.
- The mode is accepted in any state. A new mode takes effect at the next ARB.

**State machine**
- SPLASH
  - Counter runs from 0 to SPLASH_CYCLES-1, then the FSM goes to WAIT.
  - `splash_active` = 1 throughout.
  - Input requests are ignored.
- WAIT
  - `step_cnt` runs from 0 to STEP_PERIOD-1.
  - At terminal count, `step_cnt` clears and the FSM goes to ARB.
- ARB
  - In a single-source mode, the only candidate is that source.
  - In mode 00, search order starts at `rr_ptr`+1 (mod 3) and takes the first requesting source.
  - If no source is requesting, `grant` = 0 and the FSM returns to WAIT.
  - Otherwise, latch `grant`, dx and dy, then go to MOVE.
- MOVE
  - Apply dx and dy with saturation: -1 at 0 is ignored, and +1 at MAX_C / MAX_R is ignored. The two axes are independent.
  - `step_pulse` = 1 for this cycle.
  - In mode 00, `rr_ptr` is set to the granted index.
  - Next state is WAIT.
- The slot period is therefore STEP_PERIOD + 2 cycles when a move occurs, and STEP_PERIOD + 1 when ARB finds no request.

**Reset values**
- `pos_c` = INIT_C, `pos_r` = INIT_R.
- `splash_active` = 1, `mode` = 2'b11.
- `grant` = 0, `step_pulse` = 0.
- `rr_ptr` = 2, so buttons take first priority.
- State = SPLASH, with all counters at 0.

## Timing
- Input registers add 1 cycle. Decode is combinational from those registers into ARB.
- Position and `step_pulse` are registered. Both change on the clock edge that leaves MOVE.
- `grant` holds from the ARB exit until the next ARB; it is cleared when ARB finds no request.
- `splash_active` falls on the same edge on which the FSM enters WAIT.
- A mode edge arriving in the same cycle as ARB does not affect that arbitration, because the registered mode updates at the same edge.
- Asserting `rst` in any state returns all outputs to their reset values on the next edge. No partial move is applied.
- Counter widths must hold SPLASH_CYCLES-1 and STEP_PERIOD-1 (27 and 18 bits at the defaults).

## Test plan
The bench uses SPLASH_CYCLES = 16 and STEP_PERIOD = 8.
- **Reset and splash.** Assert `rst` for 2 cycles, then release → `splash_active` = 1 for 16 cycles. `pos_c`/`pos_r` = 320/240, `mode` = 11 and `step_pulse` = 0 until the first WAIT. Button d held low during SPLASH causes no move.
- **Buttons mode with saturation.** Force `pos_c` to 0 via repeated left slots, holding d and b low together → `pos_c` stays 0 (d wins, saturated), with `step_pulse` still 1 per slot and `grant` = 001. Then hold c low → `pos_r` increments once per 10-cycle slot.
- **Mode stepping.** Hold `js_button_f_d` high for 50 cycles → `mode` goes 11 → 10 only. Three further pulses → `mode` goes 01, then 00, then 11.
- **Accelerometer and joystick decode.** In mode 10, accel x = 16'hFF00 → `pos_c` +1 per slot. In mode 01, joystick x = 12'hFFF and y = 12'h000 → `pos_c` +1 and `pos_r` +1 per slot. Joystick x = 12'h800 → no move and `grant` = 0.
- **Round-robin.** In mode 00, with all three sources requesting continuously → grants cycle 001, 010, 100, 001 over consecutive slots. With only accel requesting → `grant` = 010 every slot.
- **Reset mid-MOVE.** Assert `rst` in the MOVE cycle → the next edge shows `pos` = 320/240 (no step applied), `step_pulse` = 0 and state SPLASH.
